cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Moore control FSM that drives the fetch datapath (PC, instruction RAM, instruction register) and the register-file/ALU datapath. It owns the fetch/decode/execute sequencing. It issues loadpc, loadir, msel and mwrite to the fetch stage, and it decodes the instruction-register contents into register-file and ALU strobes. The fetch stage is the responder to this block.

Parameters:
RAM_WAIT, 1, number of extra wait cycles after presenting a RAM address before mdata is valid; legal range 0..3.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; forces state RST
ir  input  16  instruction register contents; fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm
loadpc  output  1  PC <= PC+1 this edge
loadir  output  1  IR <= mdata this edge
msel  output  1  RAM address select: 0 = PC, 1 = C[7:0]
mwrite  output  1  RAM write enable; data is the B register
nsel  output  3  one-hot register select: 001 = Rm, 010 = Rd, 100 = Rn; 000 when idle
vsel  output  2  writeback source: 00 = C, 01 = sign-extended imm8, 10 = mdata
write  output  1  register-file write
loada, loadb, loadc, loads  output  1 each  datapath register enables
asel  output  1  1 = ALU A input forced to 0
bsel  output  1  1 = ALU B input = sign-extended imm5
halted  output  1  high while in HALT

Behaviour:
- Outputs are a pure decode of the current state plus ir fields. No output is registered.
- Every output is 0 in RST and in any state where the output is not listed.
- reset=1 at any edge puts the FSM in RST, including mid-instruction. There are no partial-state side effects: outputs drop to 0 the cycle after.
- The fetch stage receives the same reset, which clears the PC.
- States and transitions:
  - RST -> FETCH.
  - FETCH: msel=0. Goes to FWAIT if RAM_WAIT>0, else to LOADIR.
  - FWAIT: msel=0. A 2-bit wait counter is loaded on entry. Stays for exactly RAM_WAIT cycles, then goes to LOADIR.
  - LOADIR: msel=0, loadir=1 -> UPDPC.
  - UPDPC: loadpc=1 -> DECODE.
  - DECODE: no strobes. Dispatches on {opcode, op}:
    - 110_10 MOV imm -> WRREG.
    - 110_00 MOV reg -> GETB.
    - 101_11 MVN -> GETB.
    - 101_00 ADD, 101_01 CMP, 101_10 AND -> GETA.
    - 011_00 LDR -> GETA.
    - 100_00 STR -> GETA.
    - 111_xx -> HALT.
    - Any other encoding is a NOP and goes to FETCH.
  - GETA: nsel=Rn, loada=1. Goes to MADDR for LDR/STR, else to GETB.
  - GETB: loadb=1. nsel=Rd for STR, else Rm. Goes to MWRITE for STR, else to EXEC.
  - EXEC: loadc=1, except CMP where loadc=0 and loads=1. asel=1 for MOV reg and MVN. CMP goes to FETCH; all others go to WRREG.
  - WRREG: write=1. For MOV imm: nsel=Rn, vsel=01. Otherwise: nsel=Rd, vsel=00. -> FETCH.
  - MADDR: bsel=1, loadc=1 (C = Rn + imm5). LDR goes to MREAD; STR goes to GETB.
  - MREAD: msel=1. Goes to MWAIT if RAM_WAIT>0, else to MWB.
  - MWAIT: msel=1 for RAM_WAIT cycles -> MWB.
  - MWB: msel=1, nsel=Rd, vsel=10, write=1 -> FETCH.
  - MWRITE: msel=1, mwrite=1 -> FETCH.
  - HALT: halted=1. Stays until reset. loadpc and loadir stay 0, so the PC is frozen.
- Invariants:
  - msel=0 in every state that asserts loadir.
  - mwrite is asserted for exactly one cycle per STR.
  - loadpc is asserted exactly once per fetched instruction.
  - write and mwrite are never asserted together.
- Cycle counts with RAM_WAIT=1 are measured FETCH to FETCH; fetch overhead is 4 cycles.
  - MOV imm = 6
  - MOV reg/MVN = 8
  - ADD/AND = 9
  - CMP = 8
  - LDR = 10
  - STR = 9
  - Each additional RAM_WAIT step adds 1 cycle to the fetch, and 1 more to LDR.

Test Plan:
- Reset sequence: reset high for 2 cycles, then low, RAM_WAIT=1 -> all outputs 0 in RST. FETCH follows with msel=0. loadir=1 on the 3rd cycle after RST and loadpc=1 on the 4th.
- ir=16'hD007 (MOV R0,#7) -> in WRREG: nsel=100, vsel=01, write=1. Returns to FETCH 6 cycles after the previous FETCH.
- ir=16'hA140 (ADD R2,R1,R0) -> sequence:
  - GETA: nsel=100, loada.
  - GETB: nsel=001, loadb.
  - EXEC: loadc.
  - WRREG: nsel=010, write.
  - 9 cycles total.
- ir=16'h6022 (LDR R1,[R0,#2]), RAM_WAIT=2 -> MADDR has bsel=1, loadc=1. msel=1 for MREAD + 2 MWAIT + MWB. MWB has vsel=10, nsel=010, write=1.
- ir=16'h8022 (STR R1,[R0,#2]) -> GETB has nsel=010. MWRITE has msel=1 and mwrite=1 for exactly one cycle. write stays 0 throughout.
- ir=16'hE000 (HALT) -> halted=1 with loadpc=0 held for 20 cycles. Asserting reset mid-MWAIT of an LDR -> next cycle is RST with write=0.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: Moore control FSM sequencing fetch/decode/execute.
// Drives fetch strobes (loadpc, loadir, msel, mwrite) and regfile/ALU strobes.
module cpu_controller #(
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output logic        loadpc,
  output logic        loadir,
  output logic        msel,
  output logic        mwrite,
  output logic [2:0]  nsel,
  output logic [1:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        halted
);

  typedef enum logic [3:0] {
    RST, FETCH, FWAIT, LOADIR, UPDPC, DECODE,
    GETA, GETB, EXEC, WRREG, MADDR, MREAD,
    MWAIT, MWB, MWRITE, HALT
  } state_t;

  // Counter preload so that a wait state lasts exactly RAM_WAIT cycles.
  localparam logic [1:0] WAIT_INIT =
    (RAM_WAIT > 0) ? 2'(RAM_WAIT - 1) : 2'd0;
  localparam bit HAS_WAIT = (RAM_WAIT > 0);

  state_t     state;
  logic [1:0] cnt;

  logic [2:0] opc;
  logic [1:0] op;
  logic is_movi, is_movr, is_mvn, is_add, is_cmp;
  logic is_and, is_ldr, is_str, is_halt;

  assign opc = ir[15:13];
  assign op  = ir[12:11];

  assign is_movi = (opc == 3'b110) && (op == 2'b10);
  assign is_movr = (opc == 3'b110) && (op == 2'b00);
  assign is_mvn  = (opc == 3'b101) && (op == 2'b11);
  assign is_add  = (opc == 3'b101) && (op == 2'b00);
  assign is_cmp  = (opc == 3'b101) && (op == 2'b01);
  assign is_and  = (opc == 3'b101) && (op == 2'b10);
  assign is_ldr  = (opc == 3'b011) && (op == 2'b00);
  assign is_str  = (opc == 3'b100) && (op == 2'b00);
  assign is_halt = (opc == 3'b111);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST;
      cnt   <= 2'd0;
    end else begin
      unique case (state)
        RST:    state <= FETCH;
        FETCH: begin
          cnt   <= WAIT_INIT;
          state <= HAS_WAIT ? FWAIT : LOADIR;
        end
        FWAIT: begin
          if (cnt == 2'd0) state <= LOADIR;
          else cnt <= cnt - 2'd1;
        end
        LOADIR: state <= UPDPC;
        UPDPC:  state <= DECODE;
        DECODE: begin
          unique case (1'b1)
            is_movi:                   state <= WRREG;
            is_movr, is_mvn:           state <= GETB;
            is_add, is_cmp, is_and:    state <= GETA;
            is_ldr, is_str:            state <= GETA;
            is_halt:                   state <= HALT;
            default:                   state <= FETCH;
          endcase
        end
        GETA:   state <= (is_ldr || is_str) ? MADDR : GETB;
        GETB:   state <= is_str ? MWRITE : EXEC;
        EXEC:   state <= is_cmp ? FETCH : WRREG;
        WRREG:  state <= FETCH;
        MADDR:  state <= is_ldr ? MREAD : GETB;
        MREAD: begin
          cnt   <= WAIT_INIT;
          state <= HAS_WAIT ? MWAIT : MWB;
        end
        MWAIT: begin
          if (cnt == 2'd0) state <= MWB;
          else cnt <= cnt - 2'd1;
        end
        MWB:    state <= FETCH;
        MWRITE: state <= FETCH;
        HALT:   state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  always_comb begin
    loadpc = 1'b0;
    loadir = 1'b0;
    msel   = 1'b0;
    mwrite = 1'b0;
    nsel   = 3'b000;
    vsel   = 2'b00;
    write  = 1'b0;
    loada  = 1'b0;
    loadb  = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    asel   = 1'b0;
    bsel   = 1'b0;
    halted = 1'b0;
    unique case (state)
      LOADIR: loadir = 1'b1;
      UPDPC:  loadpc = 1'b1;
      GETA: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      GETB: begin
        loadb = 1'b1;
        nsel  = is_str ? 3'b010 : 3'b001;
      end
      EXEC: begin
        loadc = ~is_cmp;
        loads = is_cmp;
        asel  = is_movr | is_mvn;
      end
      WRREG: begin
        write = 1'b1;
        nsel  = is_movi ? 3'b100 : 3'b010;
        vsel  = is_movi ? 2'b01 : 2'b00;
      end
      MADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      MREAD, MWAIT: msel = 1'b1;
      MWB: begin
        msel  = 1'b1;
        nsel  = 3'b010;
        vsel  = 2'b10;
        write = 1'b1;
      end
      MWRITE: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed bench for cpu_controller with RAM_WAIT=1 and 2.
// A phase-level instruction model produces the expected per-cycle outputs.
module tb_cpu_controller;

  typedef struct packed {
    logic       loadpc;
    logic       loadir;
    logic       msel;
    logic       mwrite;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       halted;
  } ov_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        sel = 1'b0;

  logic loadpc_a, loadir_a, msel_a, mwrite_a, write_a;
  logic loada_a, loadb_a, loadc_a, loads_a, asel_a, bsel_a, halted_a;
  logic [2:0] nsel_a;
  logic [1:0] vsel_a;
  logic loadpc_b, loadir_b, msel_b, mwrite_b, write_b;
  logic loada_b, loadb_b, loadc_b, loads_b, asel_b, bsel_b, halted_b;
  logic [2:0] nsel_b;
  logic [1:0] vsel_b;

  ov_t out_a, out_b;
  ov_t exp_q[$];
  ov_t pq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  always #5 clk = ~clk;

  cpu_controller #(.RAM_WAIT(1)) dut_a (
    .clk(clk), .reset(reset), .ir(ir),
    .loadpc(loadpc_a), .loadir(loadir_a), .msel(msel_a),
    .mwrite(mwrite_a), .nsel(nsel_a), .vsel(vsel_a),
    .write(write_a), .loada(loada_a), .loadb(loadb_a),
    .loadc(loadc_a), .loads(loads_a), .asel(asel_a),
    .bsel(bsel_a), .halted(halted_a)
  );

  cpu_controller #(.RAM_WAIT(2)) dut_b (
    .clk(clk), .reset(reset), .ir(ir),
    .loadpc(loadpc_b), .loadir(loadir_b), .msel(msel_b),
    .mwrite(mwrite_b), .nsel(nsel_b), .vsel(vsel_b),
    .write(write_b), .loada(loada_b), .loadb(loadb_b),
    .loadc(loadc_b), .loads(loads_b), .asel(asel_b),
    .bsel(bsel_b), .halted(halted_b)
  );

  assign out_a = {loadpc_a, loadir_a, msel_a, mwrite_a, nsel_a,
                  vsel_a, write_a, loada_a, loadb_a, loadc_a,
                  loads_a, asel_a, bsel_a, halted_a};
  assign out_b = {loadpc_b, loadir_b, msel_b, mwrite_b, nsel_b,
                  vsel_b, write_b, loada_b, loadb_b, loadc_b,
                  loads_b, asel_b, bsel_b, halted_b};

  // Expected output sequence for one instruction, FETCH up to next FETCH.
  function automatic void plan(input logic [15:0] i, input int rw,
                               input int nh);
    ov_t v;
    logic [4:0] k;
    k = i[15:11];
    pq.delete();
    v = '0;
    pq.push_back(v);
    for (int n = 0; n < rw; n++) pq.push_back(v);
    v.loadir = 1'b1;
    pq.push_back(v);
    v = '0; v.loadpc = 1'b1;
    pq.push_back(v);
    v = '0;
    pq.push_back(v);
    if (k[4:2] == 3'b111) begin
      for (int n = 0; n < nh; n++) begin
        v = '0; v.halted = 1'b1; pq.push_back(v);
      end
    end else if (k == 5'b110_10) begin
      v = '0; v.write = 1; v.nsel = 3'b100; v.vsel = 2'b01;
      pq.push_back(v);
    end else if (k == 5'b110_00 || k == 5'b101_11 ||
                 k[4:2] == 3'b101) begin
      if (k[4:2] == 3'b101 && k != 5'b101_11) begin
        v = '0; v.nsel = 3'b100; v.loada = 1; pq.push_back(v);
      end
      v = '0; v.nsel = 3'b001; v.loadb = 1; pq.push_back(v);
      v = '0;
      if (k == 5'b101_01) v.loads = 1;
      else v.loadc = 1;
      v.asel = (k == 5'b110_00 || k == 5'b101_11);
      pq.push_back(v);
      if (k != 5'b101_01) begin
        v = '0; v.write = 1; v.nsel = 3'b010; pq.push_back(v);
      end
    end else if (k == 5'b011_00 || k == 5'b100_00) begin
      v = '0; v.nsel = 3'b100; v.loada = 1; pq.push_back(v);
      v = '0; v.bsel = 1; v.loadc = 1; pq.push_back(v);
      if (k == 5'b011_00) begin
        v = '0; v.msel = 1;
        for (int n = 0; n <= rw; n++) pq.push_back(v);
        v.nsel = 3'b010; v.vsel = 2'b10; v.write = 1;
        pq.push_back(v);
      end else begin
        v = '0; v.nsel = 3'b010; v.loadb = 1; pq.push_back(v);
        v = '0; v.msel = 1; v.mwrite = 1; pq.push_back(v);
      end
    end
  endfunction

  always @(negedge clk) begin
    ov_t e, g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sel ? out_b : out_a;
      vectors++;
      if (g !== e)
        begin
          miscompares++;
          $display("FAIL cycle %0d dut%s ir=%h got=%h want=%h",
                   cyc, sel ? "B" : "A", ir, g, e);
        end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back('0);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [15:0] i, input int lim);
    int n;
    ir = i;
    plan(i, sel ? 2 : 1, 20);
    n = pq.size();
    if (lim >= 0 && lim < n) n = lim;
    for (int k = 0; k < n; k++) exp_q.push_back(pq[k]);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    plan(16'hD007, 1, 0); chk("len_movi", pq.size(), 6);
    plan(16'hC041, 1, 0); chk("len_movr", pq.size(), 8);
    plan(16'hB841, 1, 0); chk("len_mvn", pq.size(), 8);
    plan(16'hA140, 1, 0); chk("len_add", pq.size(), 9);
    chk("add_geta", int'(pq[5]), 'h01040);
    plan(16'hB240, 1, 0); chk("len_and", pq.size(), 9);
    plan(16'hA901, 1, 0); chk("len_cmp", pq.size(), 8);
    plan(16'h6022, 1, 0); chk("len_ldr", pq.size(), 10);
    plan(16'h8022, 1, 0); chk("len_str", pq.size(), 9);
    plan(16'h0000, 1, 0); chk("len_nop", pq.size(), 5);
    plan(16'hD007, 2, 0); chk("len_movi_w2", pq.size(), 7);
    plan(16'h6022, 2, 0); chk("len_ldr_w2", pq.size(), 12);
    chk("ldr_w2_mwb", int'(pq[11]), 'h04A80);

    sel = 1'b0;
    do_reset();
    run(16'hD007, -1);
    run(16'hA140, -1);
    run(16'hC041, -1);
    run(16'hB841, -1);
    run(16'hA901, -1);
    run(16'hB240, -1);
    run(16'h6022, -1);
    run(16'h8022, -1);
    run(16'h0000, -1);
    run(16'hC800, -1);
    run(16'h6800, -1);
    run(16'h8800, -1);
    run(16'hD007, -1);
    run(16'hE000, -1);
    do_reset();
    run(16'hA140, -1);

    sel = 1'b1;
    do_reset();
    run(16'hD007, -1);
    run(16'h6022, -1);
    run(16'h8022, -1);
    run(16'h6022, 10);
    do_reset();
    run(16'hA901, -1);
    run(16'hE000, -1);

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
